mmio_bus_ctrl: RTL



---
 rtl/mmio_bus_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: decodes master requests onto NSLAVE base/mask windows with wait states and decode errors.
// Optional bus timeout is enabled by defining MMIO_BUS_TIMEOUT_EN.
`ifndef MEM_READ
`define MEM_READ 1'b0
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 1'b1
`endif

module mmio_bus_ctrl #(
  parameter int unsigned            NSLAVE   = 2,
  parameter logic [NSLAVE*32-1:0]   SLV_BASE = {32'ha0000000, 32'h00000000},
  parameter logic [NSLAVE*32-1:0]   SLV_MASK = {32'hff000000, 32'hf0000000},
  parameter int unsigned            TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m_req,
  input  logic                   m_rw,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_wdata,
  output logic                   m_ack,
  output logic                   m_err,
  output logic [31:0]            m_rdata,
  output logic                   m_busy,
  output logic [NSLAVE-1:0]      s_sel,
  output logic                   s_rw,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  input  logic [NSLAVE*32-1:0]   s_rdata,
  input  logic [NSLAVE-1:0]      s_ready
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  if (NSLAVE < 1 || NSLAVE > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_chk
    $error("mmio_bus_ctrl: parameter out of range");
  end

  state_t            r_state, w_state_nxt;
  logic [NSLAVE-1:0] r_sel, w_sel_nxt;
  logic              r_rw, w_rw_nxt;
  logic [DW-1:0]     r_addr, w_addr_nxt;
  logic [DW-1:0]     r_wdata, w_wdata_nxt;
  logic              r_ack, w_ack_nxt;
  logic              r_err, w_err_nxt;
  logic [DW-1:0]     r_rdata, w_rdata_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_pend_err, w_pend_err_nxt;
  logic [DW-1:0]     r_pend_rdata, w_pend_rdata_nxt;
`ifdef MMIO_BUS_TIMEOUT_EN
  localparam int unsigned CNTW = 8;
  logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
`endif

  logic [NSLAVE-1:0] w_hit;
  logic [DW-1:0]     w_hit_off;
  logic [DW-1:0]     w_sel_rdata;
  logic              w_sel_ready;

  // Window decode; scanning downward lets the lowest matching index win.
  always_comb begin
    w_hit     = '0;
    w_hit_off = '0;
    for (int i = int'(NSLAVE) - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        w_hit     = NSLAVE'(1) << i;
        w_hit_off = m_addr - SLV_BASE[32*i +: 32];
      end
    end
  end

  // Only the selected slave's ready/rdata are visible to the FSM.
  always_comb begin
    w_sel_rdata = '0;
    w_sel_ready = 1'b0;
    for (int i = 0; i < int'(NSLAVE); i++) begin
      if (r_sel[i]) begin
        w_sel_rdata = w_sel_rdata | s_rdata[32*i +: 32];
        w_sel_ready = w_sel_ready | s_ready[i];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_rw_nxt         = r_rw;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_ack_nxt        = 1'b0;
    w_err_nxt        = r_err;
    w_rdata_nxt      = r_rdata;
    w_pend_err_nxt   = r_pend_err;
    w_pend_rdata_nxt = r_pend_rdata;
`ifdef MMIO_BUS_TIMEOUT_EN
    w_cnt_nxt        = r_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (m_req) begin
          if (|w_hit) begin
            w_sel_nxt   = w_hit;
            w_rw_nxt    = m_rw;
            w_addr_nxt  = w_hit_off;
            w_wdata_nxt = m_wdata;
            w_state_nxt = ST_WAIT;
`ifdef MMIO_BUS_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
          end else begin
            w_pend_err_nxt   = 1'b1;
            w_pend_rdata_nxt = '0;
            w_state_nxt      = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (w_sel_ready) begin
          w_pend_err_nxt   = 1'b0;
          w_pend_rdata_nxt = (r_rw == `MEM_READ) ? w_sel_rdata : '0;
          w_sel_nxt        = '0;
          w_state_nxt      = ST_RESP;
        end
`ifdef MMIO_BUS_TIMEOUT_EN
        else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
          w_pend_err_nxt   = 1'b1;
          w_pend_rdata_nxt = '0;
          w_sel_nxt        = '0;
          w_state_nxt      = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
`endif
      end
      ST_RESP: begin
        // Response is held in pend regs so m_err/m_rdata change only with ack.
        w_ack_nxt   = 1'b1;
        w_err_nxt   = r_pend_err;
        w_rdata_nxt = r_pend_rdata;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_busy       <= 1'b0;
      r_pend_err   <= 1'b0;
      r_pend_rdata <= '0;
`ifdef MMIO_BUS_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_rw         <= w_rw_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_ack        <= w_ack_nxt;
      r_err        <= w_err_nxt;
      r_rdata      <= w_rdata_nxt;
      r_busy       <= w_busy_nxt;
      r_pend_err   <= w_pend_err_nxt;
      r_pend_rdata <= w_pend_rdata_nxt;
`ifdef MMIO_BUS_TIMEOUT_EN
      r_cnt        <= w_cnt_nxt;
`endif
    end
  end

  assign m_ack   = r_ack;
  assign m_err   = r_err;
  assign m_rdata = r_rdata;
  assign m_busy  = r_busy;
  assign s_sel   = r_sel;
  assign s_rw    = r_rw;
  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;

endmodule
